// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       full,
  output logic                       wr_en,
  output logic [WIDTH-1:0]           data_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ or MAX_BURST out of range");
  end

  logic [IdW-1:0] rr_ptr_q;
  logic [IdW-1:0] scan_id;
  logic [IdW-1:0] win_id;
  logic [IdW-1:0] nxt_id;
  logic           scan_found;
  logic           win_found;
  logic           hold_owner;
  logic           accept;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    scan_found = 1'b0;
    scan_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!scan_found && req_valid[idx]) begin
        scan_found = 1'b1;
        scan_id    = IdW'(idx);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e         state_q;
  logic [IdW-1:0] owner_q;
  logic [7:0]     beat_cnt_q;

  // A locked owner wins outright; once it drops valid the normal scan takes over this cycle.
  assign hold_owner = (state_q == StLock) && req_valid[owner_q];
  assign win_id     = hold_owner ? owner_q : scan_id;
  assign locked     = (state_q == StLock);
`else
  assign hold_owner = 1'b0;
  assign win_id     = scan_id;
  assign locked     = 1'b0;
`endif

  assign win_found = hold_owner | scan_found;
  assign accept    = win_found & ~full & rst_n;
  assign nxt_id    = (win_id == IdW'(NUM_REQ - 1)) ? '0 : win_id + IdW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign wr_en    = accept;
  assign grant_id = win_found ? win_id : '0;
  assign data_in  = req_data[int'(win_id)*WIDTH +: WIDTH];

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      state_q    <= StIdle;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      // While locked rr_ptr already equals owner+1, so this is a no-op for owner beats.
      if (accept) begin
        rr_ptr_q <= nxt_id;
      end
      if (!full) begin
        unique case (state_q)
          StIdle: begin
            if (accept && MAX_BURST > 1) begin
              state_q    <= StLock;
              owner_q    <= win_id;
              beat_cnt_q <= 8'd1;
            end
          end
          StLock: begin
            if (hold_owner) begin
              if (beat_cnt_q == 8'(MAX_BURST - 1)) begin
                state_q    <= StIdle;
                beat_cnt_q <= '0;
              end else begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
              end
            end else if (accept && MAX_BURST > 1) begin
              owner_q    <= win_id;
              beat_cnt_q <= 8'd1;
            end else begin
              state_q    <= StIdle;
              beat_cnt_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= nxt_id;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; burst scenarios run when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned MB = 3;
`else
  localparam int unsigned MB = 4;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [N-1:0]   req_ready;
  logic           full = 1'b0;
  logic           wr_en;
  logic [W-1:0]   data_in;
  logic [1:0]     grant_id;
  logic           locked;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .WIDTH    (W),
    .NUM_REQ  (N),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .full     (full),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .grant_id (grant_id),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the combinational handshake for one cycle: winner g, accepted or stalled.
  task automatic expect_beat(input string tag, input int g, input logic acc);
    logic [N-1:0] rdy;
    logic [W-1:0] dat;
    rdy = acc ? (N'(1) << g) : '0;
    dat = 8'hA0 + 8'(g);
    chk({tag, "/grant"}, 32'(grant_id), 32'(g));
    chk({tag, "/wr_en"}, 32'(wr_en), 32'(acc));
    chk({tag, "/ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, "/data"}, 32'(data_in), 32'(dat));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks immediate gating, releases after the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "/rst_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "/rst_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "/rst_locked"}, 32'(locked), 32'd0);
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
`ifdef FIFO_ARB_BURST_EN
    int bg[7] = '{0, 0, 0, 2, 2, 2, 0};
    int bl[7] = '{0, 1, 1, 0, 1, 1, 0};
`endif
    next();
    // Still in reset with nobody valid.
    expect_beat("reset_idle", 0, 1'b0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;

`ifndef FIFO_ARB_BURST_EN
    // Per-beat round robin with all four valid.
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'hF;
      #1;
      expect_beat($sformatf("rr%0d", c), rr_exp[c], 1'b1);
      chk($sformatf("rr%0d/locked", c), 32'(locked), 32'd0);
      next();
    end
    req_valid = 4'hF;
    do_reset("rr_reset");
`endif

    // Full stall: producers 1 and 2 valid, full for three cycles.
    req_valid = '0;
    do_reset("stall_pre");
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0110;
      full = 1'b1;
      #1;
      expect_beat($sformatf("stall%0d", c), 1, 1'b0);
      next();
    end
    full = 1'b0;
    #1;
    expect_beat("stall_rel1", 1, 1'b1);
    next();
    req_valid = 4'b0100;
    #1;
    expect_beat("stall_rel2", 2, 1'b1);
    next();

    // Sparse: only 3, then only 0 (rr_ptr wraps 3 -> 0), then nobody.
    req_valid = '0;
    do_reset("sparse_pre");
    req_valid = 4'b1000;
    #1;
    expect_beat("sparse3", 3, 1'b1);
    next();
    req_valid = 4'b0001;
    #1;
    expect_beat("sparse0", 0, 1'b1);
    next();
    req_valid = 4'b0000;
    #1;
    expect_beat("sparse_none", 0, 1'b0);
    next();

`ifdef FIFO_ARB_BURST_EN
    // Burst limit with producers 0 and 2 always valid.
    do_reset("burst_pre");
    for (int c = 0; c < 7; c++) begin
      req_valid = 4'b0101;
      #1;
      expect_beat($sformatf("burst%0d", c), bg[c], 1'b1);
      chk($sformatf("burst%0d/locked", c), 32'(locked), 32'(bl[c]));
      next();
    end

    // Early release: owner 1 drops valid after two beats, producer 3 taken same cycle.
    req_valid = '0;
    do_reset("early_pre");
    req_valid = 4'b0010;
    #1;
    expect_beat("early_b1", 1, 1'b1);
    next();
    req_valid = 4'b1010;
    #1;
    expect_beat("early_b2", 1, 1'b1);
    chk("early_b2/locked", 32'(locked), 32'd1);
    next();
    req_valid = 4'b1000;
    #1;
    expect_beat("early_sw", 3, 1'b1);
    next();
    #1;
    chk("early_newlock", 32'(locked), 32'd1);

    // Full held inside a lock, then reset mid-burst.
    req_valid = '0;
    do_reset("lockfull_pre");
    req_valid = 4'hF;
    #1;
    expect_beat("lf_b1", 0, 1'b1);
    next();
    for (int c = 0; c < 2; c++) begin
      full = 1'b1;
      #1;
      expect_beat($sformatf("lf_full%0d", c), 0, 1'b0);
      chk($sformatf("lf_full%0d/locked", c), 32'(locked), 32'd1);
      next();
    end
    full = 1'b0;
    #1;
    expect_beat("lf_b2", 0, 1'b1);
    next();
    chk("lf_locked_pre_rst", 32'(locked), 32'd1);
    do_reset("midburst");
    #1;
    expect_beat("post_rst", 0, 1'b1);
    chk("post_rst/locked", 32'(locked), 32'd0);
    next();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the team's synchronous FIFO (`wr_en`/`data_in`/`full`) between `NUM_REQ` independent producers. Each producer uses a valid/ready handshake. The arbiter grants at most one producer per cycle and never writes while the FIFO is full. An optional burst-lock mode lets a winner keep the port for consecutive beats. The block sits directly in front of the FIFO; the FIFO read side is untouched.

## Interface

Parameters:
- `WIDTH`, 8: data width; must match the FIFO `WIDTH`.
- `NUM_REQ`, 4: number of producers; range 2..16.
- `MAX_BURST`, 4: maximum beats per lock, range 1..255. Used only with `FIFO_ARB_BURST_EN`.

Ports:
- `clk`, input, 1: single clock; rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, `NUM_REQ`: bit i is high when producer i has a beat.
- `req_data`, input, `NUM_REQ*WIDTH`: producer i data in slice `[i*WIDTH +: WIDTH]`.
- `req_ready`, output, `NUM_REQ`: one-hot or zero; bit i high means producer i's beat is taken this cycle.
- `full`, input, 1: FIFO full flag.
- `wr_en`, output, 1: FIFO write enable.
- `data_in`, output, `WIDTH`: FIFO write data.
- `grant_id`, output, `$clog2(NUM_REQ)`: index of the current winner; 0 when there is no winner.
- `locked`, output, 1: high while in LOCK state.

## Operation

- **Accept rule:** a beat from producer i is accepted when `req_valid[i]`, i is the winner, and `!full`.
  - On accept: `req_ready[i]=1`, `wr_en=1`, `data_in` = slice i.
  - `wr_en` equals `|req_ready`.
- **Winner selection (IDLE):** the first i with `req_valid[i]` high, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- **Round-robin update:** on an accept in IDLE, `rr_ptr` becomes (winner+1) mod `NUM_REQ`.
- **Full:** with `full` high, no accept occurs. `rr_ptr`, state and beat count are unchanged, and `grant_id` still shows the would-be winner.
- **No valid requester:** `req_ready=0`, `wr_en=0`, `grant_id=0`, `data_in` = slice 0.
- **Without `FIFO_ARB_BURST_EN`:** the state machine is permanently IDLE and `locked=0`.
- **State machine (burst build only):**
  - IDLE -> LOCK on an accept when `MAX_BURST>1`. Then `owner` = winner, `beat_cnt` = 1, `rr_ptr` = owner+1.
  - In LOCK, when `req_valid[owner]` is high: the winner is `owner`, whatever the other requests are. An accept increments `beat_cnt`. An accept that makes `beat_cnt`==`MAX_BURST` returns the state to IDLE.
  - In LOCK, when `req_valid[owner]` is low: the lock is released in the same cycle. Winner selection runs exactly as in IDLE from `rr_ptr`, so no bubble is inserted. The next state is IDLE, or a new LOCK if that selection accepts and `MAX_BURST>1`.
  - `full` in LOCK holds the lock, including when `full` lasts many cycles.
- **Output gating:** `req_ready` and `wr_en` are forced to 0 while `rst_n` is low.

## Timing

- Handshake outputs (`req_ready`, `wr_en`, `data_in`, `grant_id`) are combinational from the inputs and the registered state. There are zero cycles from valid to write.
- State registers are `rr_ptr`, `state`, `owner`, `beat_cnt`. They update on `posedge clk`.
- Reset values, applied asynchronously on `rst_n` falling:
  - `rr_ptr=0`, state IDLE, `owner=0`, `beat_cnt=0`.
  - `locked=0`, `wr_en=0`, `req_ready=0`.
- Reset deassertion is taken synchronously by the integrator. The first possible accept is on the first rising edge with `rst_n` high.
- Reset asserted mid-burst drops the lock immediately. The beat being presented in that cycle is not written.
- Throughput is one beat per cycle whenever `!full` and any requester is valid.
- `req_valid`/`req_data` must be stable until `req_ready`. A producer must not drop `valid` before it sees `ready` (protocol rule; checked by an assertion in the bound FV module).

## Configuration

- **`FIFO_ARB_BURST_EN` defined:** the LOCK state, `owner`, `beat_cnt` and `MAX_BURST` are active as described above.
- **`FIFO_ARB_BURST_EN` undefined:**
  - Pure per-beat round robin; `locked` is tied to 0.
  - The LOCK logic is not compiled, and `MAX_BURST` is ignored.

## Test plan

- **Round robin:** `NUM_REQ=4`, all four valid, `full=0`, burst off. Grants are 0,1,2,3,0 on consecutive cycles, `wr_en=1` on each cycle, and `data_in` follows each requester.
- **Full stall:** producers 1 and 2 valid, `full` high for 3 cycles. `wr_en=0` and `req_ready=0` throughout. On the cycle `full` drops, producer 1 is accepted, then producer 2.
- **Burst limit:** `FIFO_ARB_BURST_EN`, `MAX_BURST=3`, producers 0 and 2 always valid. Expected sequence 0,0,0,2,2,2,0; `locked` is high from the cycle after the first beat of each burst.
- **Early release:** burst on. Owner 1 drops `valid` after 2 beats while producer 3 is valid. Producer 3 is accepted in that same cycle with no idle cycle in between.
- **Reset mid-burst:** `rst_n` low during LOCK. `wr_en`, `req_ready` and `locked` go to 0 immediately. After release with all requesters valid, the first grant goes to producer 0.
- **Sparse requests:** only producer 3 is valid, then only producer 0. Each is accepted on its first valid cycle. `rr_ptr` wraps from 3 to 0.
